// File: rtl/mac_job_sequencer_if.sv
// Purpose: bundles the command, operand-memory and result signals of mac_job_sequencer.
// Latency: none; this file only declares wires and modports.
// Backpressure: cmd_valid/cmd_ready and res_valid/res_ready are plain valid/ready pairs.
// Ports: slave = sequencer side (drives cmd_ready, mem_*_addr, mem_rd_en, res_*, busy);
//        master = host + memory side (drives cmd_*, mem_*_rdata, res_ready).
interface mac_job_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_a;
    logic [ADDR_W-1:0] cmd_base_b;
    logic [LEN_W-1:0]  cmd_len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_a_addr;
    logic [ADDR_W-1:0] mem_b_addr;
    logic [DATA_W-1:0] mem_a_rdata;
    logic [DATA_W-1:0] mem_b_rdata;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_base_a, cmd_base_b, cmd_len,
        input  mem_a_rdata, mem_b_rdata, res_ready,
        output cmd_ready, mem_rd_en, mem_a_addr, mem_b_addr,
        output res_valid, res_data, busy
    );

    modport master (
        output cmd_valid, cmd_base_a, cmd_base_b, cmd_len,
        output mem_a_rdata, mem_b_rdata, res_ready,
        input  cmd_ready, mem_rd_en, mem_a_addr, mem_b_addr,
        input  res_valid, res_data, busy
    );
endinterface

// File: rtl/mac_job_sequencer.sv
// Purpose: runs one dot-product job at a time: issues operand reads, multiply-accumulates, returns the sum.
// Latency: result valid len+MEM_LAT+1 edges after the command handshake (1 edge for len=0).
// Backpressure: cmd_ready only in IDLE; the result is held stable until res_ready, jobs never overlap.
// Ports: clk, rst (async, active-high); bus = mac_job_sequencer_if.slave (command, memory, result, busy).
module mac_job_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 64,
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mac_job_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base_a;
        logic [ADDR_W-1:0] base_b;
        logic [LEN_W-1:0]  len;
    } job_t;

    localparam int DRN_W = $clog2(MEM_LAT + 2);

    state_t              r_state;
    state_t              w_state_nxt;
    job_t                r_job;
    logic [LEN_W-1:0]    r_idx;
    logic [DRN_W-1:0]    r_drain;
    logic [MEM_LAT-1:0]  r_vld_sr;
    logic [MEM_LAT-1:0]  r_first_sr;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_s1_vld;
    logic                r_s1_first;
    logic [ACC_W-1:0]    r_acc;
    logic                w_cmd_hs;
    logic                w_issue;
    logic [2*DATA_W-1:0] w_prod;

    assign w_prod       = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};
    assign bus.res_data = r_acc;

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_hs       = 1'b0;
        w_issue        = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.mem_rd_en  = 1'b0;
        bus.mem_a_addr = '0;
        bus.mem_b_addr = '0;
        bus.res_valid  = 1'b0;
        bus.busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                w_cmd_hs      = bus.cmd_valid;
                // Zero-length jobs spend one cycle in DRAIN so the (zero) result
                // appears one edge after the handshake.
                if (w_cmd_hs)
                    w_state_nxt = (bus.cmd_len == '0) ? S_DRAIN : S_ISSUE;
            end
            S_ISSUE: begin
                w_issue        = 1'b1;
                bus.mem_rd_en  = 1'b1;
                bus.mem_a_addr = r_job.base_a + ADDR_W'(r_idx);
                bus.mem_b_addr = r_job.base_b + ADDR_W'(r_idx);
                if (r_idx == r_job.len - LEN_W'(1))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Counter reaches MEM_LAT on the cycle ending with the last accumulate edge.
                if (r_drain == DRN_W'(MEM_LAT))
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_job      <= '0;
            r_idx      <= '0;
            r_drain    <= '0;
            r_vld_sr   <= '0;
            r_first_sr <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (w_cmd_hs) begin
                r_job.base_a <= bus.cmd_base_a;
                r_job.base_b <= bus.cmd_base_b;
                r_job.len    <= bus.cmd_len;
                r_idx        <= '0;
                r_drain      <= (bus.cmd_len == '0) ? DRN_W'(MEM_LAT) : '0;
            end else begin
                if (w_issue)
                    r_idx <= r_idx + LEN_W'(1);
                if (r_state == S_DRAIN)
                    r_drain <= r_drain + DRN_W'(1);
            end

            // Strobe tracker: the tail bit is set exactly while read data is on the bus.
            r_vld_sr[0]   <= w_issue;
            r_first_sr[0] <= w_issue && (r_idx == '0);
            for (int k = 1; k < MEM_LAT; k++) begin
                r_vld_sr[k]   <= r_vld_sr[k-1];
                r_first_sr[k] <= r_first_sr[k-1];
            end

            r_s1_vld   <= r_vld_sr[MEM_LAT-1];
            r_s1_first <= r_first_sr[MEM_LAT-1];
            if (r_vld_sr[MEM_LAT-1]) begin
                r_a <= bus.mem_a_rdata;
                r_b <= bus.mem_b_rdata;
            end

            // First element restarts the sum; zero-length jobs rely on the handshake clear.
            if (r_s1_vld)
                r_acc <= (r_s1_first ? '0 : r_acc) + ACC_W'(w_prod);
            else if (w_cmd_hs)
                r_acc <= '0;
        end
    end
endmodule

// File: tb/tb_mac_job_sequencer.sv
module tb_mac_job_sequencer;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_job_sequencer_if #(.DATA_W(32), .ACC_W(64), .ADDR_W(AW), .LEN_W(10)) ifc ();

    mac_job_sequencer #(
        .DATA_W(32), .ACC_W(64), .ADDR_W(AW), .LEN_W(10), .MEM_LAT(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [7:0]  qa [$];
    logic [7:0]  qb [$];
    int          cyc = 0;
    int          hs_edge = 0;
    int          checks = 0;
    int          errors = 0;

    // Operand memories with one cycle of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.mem_rd_en) begin
            ifc.mem_a_rdata <= mem_a[ifc.mem_a_addr];
            ifc.mem_b_rdata <= mem_b[ifc.mem_b_addr];
        end
    end

    // Log every read strobe with its addresses.
    always @(negedge clk) begin
        if (ifc.mem_rd_en) begin
            qa.push_back(ifc.mem_a_addr);
            qb.push_back(ifc.mem_b_addr);
        end
    end

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check64({tag, " cmd_ready"}, 64'(ifc.cmd_ready), 64'd1);
        check64({tag, " mem_rd_en"}, 64'(ifc.mem_rd_en), 64'd0);
        check64({tag, " a_addr"},    64'(ifc.mem_a_addr), 64'd0);
        check64({tag, " b_addr"},    64'(ifc.mem_b_addr), 64'd0);
        check64({tag, " res_valid"}, 64'(ifc.res_valid), 64'd0);
        check64({tag, " res_data"},  ifc.res_data, 64'd0);
        check64({tag, " busy"},      64'(ifc.busy), 64'd0);
    endtask

    // Reference: dot product over wrapped addresses, modulo 2^64.
    function automatic logic [63:0] dot(input logic [7:0] ba, input logic [7:0] bb, input int len);
        logic [63:0] s = 64'd0;
        for (int k = 0; k < len; k++)
            s += 64'(mem_a[8'(ba + 8'(k))]) * 64'(mem_b[8'(bb + 8'(k))]);
        return s;
    endfunction

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic start_cmd(input logic [7:0] ba, input logic [7:0] bb, input logic [9:0] len);
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_base_a = ba;
        ifc.cmd_base_b = bb;
        ifc.cmd_len    = len;
        for (int n = 0; n < 100 && !ifc.cmd_ready; n++) @(negedge clk);
        @(negedge clk);
        hs_edge        = cyc;
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_base_a = 8'($urandom);
        ifc.cmd_base_b = 8'($urandom);
        ifc.cmd_len    = 10'($urandom);
    endtask

    task automatic wait_result(output logic [63:0] data, output int lat, output bit ok);
        ok = 1'b0; data = '0; lat = -1;
        for (int n = 0; n < 300; n++) begin
            if (ifc.res_valid) begin
                ok = 1'b1; data = ifc.res_data; lat = cyc - hs_edge;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_job(input logic [7:0] ba, input logic [7:0] bb, input logic [9:0] len,
                           input logic [63:0] exp_res, input int exp_lat, input int hold,
                           input string tag);
        logic [63:0] got;
        int lat, bad;
        bit ok;
        qa.delete(); qb.delete();
        start_cmd(ba, bb, len);
        wait_result(got, lat, ok);
        check64({tag, " result seen"}, 64'(ok), 64'd1);
        if (ok) begin
            check64({tag, " res_data"}, got, exp_res);
            check64({tag, " latency"}, 64'(lat), 64'(exp_lat));
            check64({tag, " strobes"}, 64'(qa.size()), 64'(len));
            bad = 0;
            for (int k = 0; k < qa.size(); k++)
                if (qa[k] !== 8'(ba + 8'(k)) || qb[k] !== 8'(bb + 8'(k))) bad++;
            check64({tag, " addr seq"}, 64'(bad), 64'd0);
            repeat (hold) @(negedge clk);
            if (hold > 0) check64({tag, " held data"}, ifc.res_data, exp_res);
            ifc.res_ready = 1'b1;
            @(negedge clk);
            ifc.res_ready = 1'b0;
            check64({tag, " valid drop"}, 64'(ifc.res_valid), 64'd0);
        end
    endtask

    typedef struct {
        logic [7:0]  ba;
        logic [7:0]  bb;
        logic [9:0]  len;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] got;
        int lat, seen;
        bit ok;

        vecs[0] = '{8'h00, 8'h00, 10'd4, 64'd70, 6};
        vecs[1] = '{8'h00, 8'h00, 10'd0, 64'd0, 1};
        vecs[2] = '{8'h40, 8'h40, 10'd2, 64'hFFFFFFFC00000002, 4};
        vecs[3] = '{8'hFE, 8'h10, 10'd4, 64'd61, 6};
        vecs[4] = '{8'h00, 8'h00, 10'd1, 64'd5, 3};
        vecs[5] = '{8'h01, 8'h02, 10'd2, 64'd38, 4};

        for (int k = 0; k < 256; k++) begin
            mem_a[k] = $urandom;
            mem_b[k] = $urandom;
        end
        for (int k = 0; k < 4; k++) begin
            mem_a[k] = 32'(k + 1);
            mem_b[k] = 32'(k + 5);
            mem_b[8'h10 + k] = 32'(k + 1);
        end
        mem_a[8'hFE] = 32'd10;
        mem_a[8'hFF] = 32'd20;
        mem_a[8'h40] = 32'hFFFFFFFF; mem_a[8'h41] = 32'hFFFFFFFF;
        mem_b[8'h40] = 32'hFFFFFFFF; mem_b[8'h41] = 32'hFFFFFFFF;
        mem_a[8'h50] = 32'd3;
        mem_b[8'h50] = 32'd4;

        ifc.cmd_valid = 1'b0; ifc.cmd_base_a = '0; ifc.cmd_base_b = '0;
        ifc.cmd_len = '0; ifc.res_ready = 1'b0;
        ifc.mem_a_rdata = '0; ifc.mem_b_rdata = '0;

        #2 rst = 1'b1;
        #1 check_reset("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++)
            run_job(vecs[v].ba, vecs[v].bb, vecs[v].len, vecs[v].exp_res,
                    vecs[v].exp_lat, 0, $sformatf("vec%0d", v));

        // Back-pressure, then a second job right after the result handshake.
        start_cmd(8'h00, 8'h00, 10'd4);
        wait_result(got, lat, ok);
        check64("bp result seen", 64'(ok), 64'd1);
        for (int n = 0; n < 5; n++) begin
            check64("bp data stable", ifc.res_data, 64'd70);
            check64("bp cmd_ready", 64'(ifc.cmd_ready), 64'd0);
            check64("bp busy", 64'(ifc.busy), 64'd1);
            @(negedge clk);
        end
        ifc.res_ready  = 1'b1;
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_base_a = 8'hFE; ifc.cmd_base_b = 8'h10; ifc.cmd_len = 10'd4;
        @(negedge clk);
        ifc.res_ready = 1'b0;
        check64("bp valid drop", 64'(ifc.res_valid), 64'd0);
        check64("bp ready back", 64'(ifc.cmd_ready), 64'd1);
        run_job(8'hFE, 8'h10, 10'd4, 64'd61, 6, 0, "b2b");

        // Reset in the middle of issuing a len=8 job.
        start_cmd(8'h60, 8'h60, 10'd8);
        repeat (2) @(negedge clk);
        check64("mid i2 addr", 64'(ifc.mem_a_addr), 64'h62);
        rst = 1'b1;
        #1 check_reset("mid reset");
        qa.delete(); qb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ifc.res_valid) seen++;
        end
        check64("post reset strobes", 64'(qa.size()), 64'd0);
        check64("post reset res", 64'(seen), 64'd0);
        run_job(8'h50, 8'h50, 10'd1, 64'd12, 3, 0, "after reset");

        // Randomized jobs against the arithmetic reference.
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = $urandom;
            mem_b[k] = $urandom;
        end
        mem_a[0] = 32'hFFFFFFFF; mem_b[0] = 32'hFFFFFFFF;
        for (int j = 0; j < 40; j++) begin
            logic [7:0] ba, bb;
            int len;
            ba  = 8'($urandom);
            bb  = 8'($urandom);
            len = $urandom_range(0, 24);
            run_job(ba, bb, 10'(len), dot(ba, bb, len), (len == 0) ? 1 : len + 2,
                    $urandom_range(0, 3), $sformatf("rand%0d", j));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
